// File: rtl/ad_ip_jesd204_tpl_dac_up_arb.sv
// Round-robin arbiter sharing the DAC TPL up register bus between NUM_REQ requesters.
// One transaction in flight; an unresponsive address is closed out by a timeout.
module ad_ip_jesd204_tpl_dac_up_arb #(
  parameter int          NUM_REQ       = 2,
  parameter int          TIMEOUT       = 255,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEADDEAD
) (
  input  logic                    up_clk,
  input  logic                    up_rst,
  input  logic [NUM_REQ-1:0]      req_wreq,
  input  logic [NUM_REQ*14-1:0]   req_waddr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_wack,
  input  logic [NUM_REQ-1:0]      req_rreq,
  input  logic [NUM_REQ*14-1:0]   req_raddr,
  output logic [NUM_REQ*32-1:0]   req_rdata,
  output logic [NUM_REQ-1:0]      req_rack,
  output logic                    up_wreq,
  output logic [13:0]             up_waddr,
  output logic [31:0]             up_wdata,
  input  logic                    up_wack,
  output logic                    up_rreq,
  output logic [13:0]             up_raddr,
  input  logic [31:0]             up_rdata,
  input  logic                    up_rack,
  output logic                    timeout_pulse,
  output logic [15:0]             timeout_count
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic          write_q, write_d;
  logic [13:0]   waddr_q, waddr_d;
  logic [13:0]   raddr_q, raddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   tcount_q, tcount_d;
  logic          pulse_q, pulse_d;

  logic [NUM_REQ-1:0] pending;
  logic               found;
  logic [IW-1:0]      sel;
  logic [IW-1:0]      cand;

  assign pending = req_wreq | req_rreq;

  // First pending requester at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && pending[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    write_d  = write_q;
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    tcount_d = tcount_q;
    pulse_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = sel;
          write_d = req_wreq[sel];
          if (req_wreq[sel]) begin
            waddr_d = req_waddr[14*sel +: 14];
            wdata_d = req_wdata[32*sel +: 32];
          end else begin
            raddr_d = req_raddr[14*sel +: 14];
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (write_q ? up_wack : up_rack) begin
          if (!write_q) rdata_d = up_rdata;
          state_d = RESP;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          rdata_d = TIMEOUT_RDATA;
          pulse_d = 1'b1;
          if (tcount_q != 16'hFFFF) tcount_d = tcount_q + 16'd1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        ptr_d   = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      write_q  <= 1'b0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      tcount_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      write_q  <= write_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      tcount_q <= tcount_d;
      pulse_q  <= pulse_d;
    end
  end

  assign up_wreq       = (state_q == ISSUE) && write_q;
  assign up_rreq       = (state_q == ISSUE) && !write_q;
  assign up_waddr      = waddr_q;
  assign up_wdata      = wdata_q;
  assign up_raddr      = raddr_q;
  assign timeout_pulse = pulse_q;
  assign timeout_count = tcount_q;

  // Completion goes only to the granted requester; everyone else sees zero data.
  always_comb begin
    req_wack  = '0;
    req_rack  = '0;
    req_rdata = '0;
    if (state_q == RESP) begin
      if (write_q) begin
        req_wack[grant_q] = 1'b1;
      end else begin
        req_rack[grant_q]             = 1'b1;
        req_rdata[32*grant_q +: 32]   = rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_up_arb.sv
// Lockstep bench for the up bus arbiter: directed scenarios then randomized traffic
// checked against a transaction-level round-robin model.
module tb_ad_ip_jesd204_tpl_dac_up_arb;

  localparam int          NUM_REQ       = 2;
  localparam int          TIMEOUT       = 255;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADDEAD;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    reqWreq, reqRreq, reqWack, reqRack;
  logic [NUM_REQ*14-1:0] reqWaddr, reqRaddr;
  logic [NUM_REQ*32-1:0] reqWdata, reqRdata;
  logic                  upWreq, upRreq, upWack, upRack, timeoutPulse;
  logic [13:0]           upWaddr, upRaddr;
  logic [31:0]           upWdata, upRdata;
  logic [15:0]           timeoutCount;

  int vecCount = 0;
  int errCount = 0;
  int cyc = 0;
  int mPtr = 0;
  int mTcount = 0;
  int lastG = 0;
  bit lastW = 1'b0;
  int lastPeriod = 0;
  int respCyc[NUM_REQ];

  ad_ip_jesd204_tpl_dac_up_arb #(
    .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .TIMEOUT_RDATA(TIMEOUT_RDATA)
  ) dut (
    .up_clk(clk), .up_rst(rst),
    .req_wreq(reqWreq), .req_waddr(reqWaddr), .req_wdata(reqWdata), .req_wack(reqWack),
    .req_rreq(reqRreq), .req_raddr(reqRaddr), .req_rdata(reqRdata), .req_rack(reqRack),
    .up_wreq(upWreq), .up_waddr(upWaddr), .up_wdata(upWdata), .up_wack(upWack),
    .up_rreq(upRreq), .up_raddr(upRaddr), .up_rdata(upRdata), .up_rack(upRack),
    .timeout_pulse(timeoutPulse), .timeout_count(timeoutCount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int i, input bit w, input bit r,
                               input logic [13:0] addr, input logic [31:0] data);
    if (w) begin
      reqWreq[i]            = 1'b1;
      reqWaddr[14*i +: 14]  = addr;
      reqWdata[32*i +: 32]  = data;
    end
    if (r) begin
      reqRreq[i]            = 1'b1;
      reqRaddr[14*i +: 14]  = addr;
    end
  endtask

  task automatic dropGranted();
    if (lastW) reqWreq[lastG] = 1'b0;
    else       reqRreq[lastG] = 1'b0;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput(tag, 64'({upWreq, upRreq, reqWack, reqRack, timeoutPulse}), 64'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkQuiet({tag, "_strobes"});
    checkOutput({tag, "_addr"}, 64'({upWaddr, upRaddr}), 64'd0);
    checkOutput({tag, "_wdata"}, 64'(upWdata), 64'd0);
    checkOutput({tag, "_rdata"}, 64'(reqRdata), 64'd0);
    checkOutput({tag, "_tcount"}, 64'(timeoutCount), 64'd0);
  endtask

  // Called at the negedge of an idle cycle with requests already presented; returns
  // at the negedge of the response cycle.
  task automatic runTransaction(input int delay, input bit noAck, input bit noise,
                                input bit useRd, input logic [31:0] rd);
    int g;
    bit isW;
    bit done;
    int w;
    logic [13:0] ea;
    logic [31:0] ed, er;
    logic [63:0] expRd;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (mPtr + k) % NUM_REQ;
      if (g < 0 && (reqWreq[idx] || reqRreq[idx])) g = idx;
    end
    if (g < 0) begin
      $display("[TB] FAIL stimulus: runTransaction called with nothing pending");
      $fatal(1, "[TB] bench error");
    end
    isW = reqWreq[g];
    ea  = isW ? reqWaddr[14*g +: 14] : reqRaddr[14*g +: 14];
    ed  = reqWdata[32*g +: 32];
    er  = useRd ? rd : $urandom;
    checkQuiet("idle");

    @(negedge clk);
    checkOutput("issue_strobe", 64'({upWreq, upRreq}), isW ? 64'd2 : 64'd1);
    checkOutput("issue_ack", 64'({reqWack, reqRack}), 64'd0);
    checkOutput("issue_addr", 64'(isW ? upWaddr : upRaddr), 64'(ea));
    if (isW) checkOutput("issue_wdata", 64'(upWdata), 64'(ed));

    done = 1'b0;
    w = 0;
    while (!done) begin
      @(negedge clk);
      upWack = 1'b0;
      upRack = 1'b0;
      checkQuiet("wait");
      if (!noAck && w == delay) begin
        if (isW) upWack = 1'b1;
        else begin
          upRack  = 1'b1;
          upRdata = er;
        end
        done = 1'b1;
      end else if (noise && $urandom_range(0, 1) == 1) begin
        if (isW) upRack = 1'b1;
        else     upWack = 1'b1;
        upRdata = $urandom;
      end
      if (noAck && w == TIMEOUT - 1) done = 1'b1;
      w++;
    end

    @(negedge clk);
    upWack  = 1'b0;
    upRack  = 1'b0;
    upRdata = '0;
    if (noAck) begin
      er = TIMEOUT_RDATA;
      if (mTcount < 65535) mTcount++;
    end
    expRd = '0;
    if (!isW) expRd[32*g +: 32] = er;
    checkOutput("resp_wack", 64'(reqWack), isW ? 64'(1 << g) : 64'd0);
    checkOutput("resp_rack", 64'(reqRack), isW ? 64'd0 : 64'(1 << g));
    checkOutput("resp_rdata", 64'(reqRdata), expRd);
    checkOutput("resp_strobe", 64'({upWreq, upRreq}), 64'd0);
    checkOutput("resp_tpulse", 64'(timeoutPulse), 64'(noAck));
    checkOutput("resp_tcount", 64'(timeoutCount), 64'(mTcount));
    lastPeriod = cyc - respCyc[g];
    respCyc[g] = cyc;
    lastG = g;
    lastW = isW;
    mPtr  = (g + 1) % NUM_REQ;
  endtask

  initial begin
    int kind;
    rst      = 1'b1;
    reqWreq  = '0;
    reqRreq  = '0;
    reqWaddr = '0;
    reqRaddr = '0;
    reqWdata = '0;
    upWack   = 1'b0;
    upRack   = 1'b0;
    upRdata  = '0;
    for (int i = 0; i < NUM_REQ; i++) respCyc[i] = 0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    // Single write from requester 0, slave acks one cycle after the strobe.
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 14'h0010, 32'h12345678);
    runTransaction(0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Single read from requester 1.
    @(negedge clk);
    dropGranted();
    applyStimulus(1, 1'b0, 1'b1, 14'h0418, 32'd0);
    runTransaction(0, 1'b0, 1'b0, 1'b1, 32'hA5A50001);

    // Both requesters write continuously: grants alternate, one ack each per 8 cycles.
    @(negedge clk);
    dropGranted();
    applyStimulus(0, 1'b1, 1'b0, 14'($urandom), $urandom);
    applyStimulus(1, 1'b1, 1'b0, 14'($urandom), $urandom);
    for (int n = 0; n < 6; n++) begin
      runTransaction(0, 1'b0, 1'b0, 1'b0, 32'd0);
      if (n >= 2) checkOutput("rr_period", 64'(lastPeriod), 64'd8);
      @(negedge clk);
      applyStimulus(lastG, 1'b1, 1'b0, 14'($urandom), $urandom);
    end

    // Write and read together from requester 0: write first, read on the next grant.
    reqWreq = '0;
    applyStimulus(0, 1'b1, 1'b1, 14'h0123, 32'hCAFEF00D);
    runTransaction(1, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    dropGranted();
    runTransaction(2, 1'b0, 1'b0, 1'b0, 32'd0);

    // Read to an unmapped address times out; a late rack in idle is ignored.
    @(negedge clk);
    dropGranted();
    applyStimulus(0, 1'b0, 1'b1, 14'h3FF0, 32'd0);
    runTransaction(0, 1'b1, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    dropGranted();
    upRack  = 1'b1;
    upRdata = 32'h13572468;
    @(negedge clk);
    upRack  = 1'b0;
    upRdata = '0;
    checkQuiet("late_rack");
    checkOutput("late_rack_tcount", 64'(timeoutCount), 64'(mTcount));
    @(negedge clk);
    checkQuiet("late_rack_idle");

    // Reset during WAIT: no ack, all outputs clear, pointer back to 0.
    applyStimulus(1, 1'b1, 1'b0, 14'h0200, 32'h0BADBEEF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("rst_wait");
    rst     = 1'b0;
    mPtr    = 0;
    mTcount = 0;
    runTransaction(0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Pointer moves to 1, then reset during WAIT with both pending: requester 0 wins.
    @(negedge clk);
    dropGranted();
    applyStimulus(0, 1'b1, 1'b0, 14'h0044, 32'h44444444);
    applyStimulus(1, 1'b0, 1'b1, 14'h0088, 32'd0);
    runTransaction(0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 14'h0045, 32'h45454545);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("rst_both");
    rst  = 1'b0;
    mPtr = 0;
    runTransaction(0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Write timeout.
    @(negedge clk);
    reqWreq = '0;
    reqRreq = '0;
    applyStimulus(1, 1'b1, 1'b0, 14'h3FFF, 32'h77777777);
    runTransaction(0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Randomized traffic with random slave latency and stray non-matching acks.
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      dropGranted();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!reqWreq[i] && !reqRreq[i] && $urandom_range(0, 1) == 1) begin
          kind = int'($urandom_range(0, 2));
          applyStimulus(i, kind != 1, kind != 0, 14'($urandom), $urandom);
        end
      end
      if (reqWreq == '0 && reqRreq == '0)
        applyStimulus(int'($urandom_range(0, NUM_REQ - 1)), 1'b0, 1'b1, 14'($urandom), 32'd0);
      runTransaction(int'($urandom_range(0, 4)), 1'b0, 1'b1, 1'b0, 32'd0);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
